// File: rtl/retire_trace_buf.sv
// Merges per-unit retire/halt events through one-entry staging slots into a round-robin arbitrated trace FIFO.
// Strobe to trace_valid takes 2 cycles; a full FIFO stalls the arbiter. Optional per-record timestamp under TRACE_TIMESTAMP_EN.
module retire_trace_buf #(
  parameter int NUM_UNITS = 6,
  parameter int DEPTH     = 16,
  parameter int UNIT_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_UNITS-1:0]        retire_valid,
  input  logic [NUM_UNITS*32-1:0]     retire_pc,
  input  logic [NUM_UNITS*6-1:0]      retire_wfid,
  input  logic                        issue_halt,
  input  logic [5:0]                  issue_halt_wfid,
  output logic                        trace_valid,
  input  logic                        trace_ready,
  output logic [UNIT_W-1:0]           trace_unit,
  output logic [31:0]                 trace_pc,
  output logic [5:0]                  trace_wfid,
  output logic [15:0]                 trace_seq,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [15:0]                 drop_count
`ifdef TRACE_TIMESTAMP_EN
  ,output logic [31:0]                trace_ts
`endif
);

  localparam int NCH = NUM_UNITS + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;

  typedef struct packed {
    logic [UNIT_W-1:0] unit;
    logic [31:0]       pc;
    logic [5:0]        wfid;
    logic [15:0]       seq;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       ts;
`endif
  } rec_t;

  logic [NCH-1:0]    strb, slot_vld_q, gnt_oh, drop_oh;
  logic [31:0]       strb_pc     [NCH];
  logic [5:0]        strb_wfid   [NCH];
  logic [31:0]       slot_pc_q   [NCH];
  logic [5:0]        slot_wfid_q [NCH];
  logic [UNIT_W-1:0] last_q, gnt_idx;
  logic              gnt_vld, pop, can_push;
  logic [UNIT_W:0]   drop_n;
  logic [16:0]       drop_sum;
  logic [15:0]       drop_q, drop_d, seq_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  rec_t              mem_q [DEPTH];
  rec_t              push_rec, head_rec;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]       ts_q;
  logic [31:0]       slot_ts_q [NCH];
`endif

  always_comb begin
    strb = '0;
    for (int c = 0; c < NUM_UNITS; c++) begin
      strb[c]      = retire_valid[c];
      strb_pc[c]   = retire_pc[32*c +: 32];
      strb_wfid[c] = retire_wfid[6*c +: 6];
    end
    strb[NUM_UNITS]      = issue_halt;
    strb_pc[NUM_UNITS]   = '0;
    strb_wfid[NUM_UNITS] = issue_halt_wfid;
  end

  assign pop      = trace_valid && trace_ready;
  assign can_push = (level_q != LW'(DEPTH)) || pop;

  // Round robin: channels above the last grant first, then wrap to 0..last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    if (can_push) begin
      for (int c = 0; c < NCH; c++) begin
        if (!gnt_vld && slot_vld_q[c] && (UNIT_W'(c) > last_q)) begin
          gnt_vld   = 1'b1;
          gnt_idx   = UNIT_W'(c);
          gnt_oh[c] = 1'b1;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (!gnt_vld && slot_vld_q[c] && (UNIT_W'(c) <= last_q)) begin
          gnt_vld   = 1'b1;
          gnt_idx   = UNIT_W'(c);
          gnt_oh[c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    drop_oh = strb & slot_vld_q & ~gnt_oh;
    drop_n  = '0;
    for (int c = 0; c < NCH; c++) drop_n = drop_n + (UNIT_W+1)'(drop_oh[c]);
    drop_sum = {1'b0, drop_q} + 17'(drop_n);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    push_rec      = '0;
    push_rec.unit = gnt_idx;
    push_rec.pc   = slot_pc_q[gnt_idx];
    push_rec.wfid = slot_wfid_q[gnt_idx];
    push_rec.seq  = seq_q;
`ifdef TRACE_TIMESTAMP_EN
    push_rec.ts   = slot_ts_q[gnt_idx];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q <= '0;
      last_q     <= UNIT_W'(NUM_UNITS);
      seq_q      <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      // A slot granted this cycle is free for a same-cycle strobe.
      slot_vld_q <= (slot_vld_q & ~gnt_oh) | strb;
      drop_q     <= drop_d;
      if (gnt_vld) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        seq_q    <= seq_q + 16'd1;
        last_q   <= gnt_idx;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({gnt_vld, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (strb[c] && (!slot_vld_q[c] || gnt_oh[c])) begin
        slot_pc_q[c]   <= strb_pc[c];
        slot_wfid_q[c] <= strb_wfid[c];
`ifdef TRACE_TIMESTAMP_EN
        slot_ts_q[c]   <= ts_q;
`endif
      end
    end
    if (gnt_vld) mem_q[wr_ptr_q] <= push_rec;
  end

`ifdef TRACE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 32'd1;
  end
  assign trace_ts = trace_valid ? head_rec.ts : '0;
`endif

  assign head_rec    = mem_q[rd_ptr_q];
  assign trace_valid = (level_q != '0);
  assign trace_unit  = trace_valid ? head_rec.unit : '0;
  assign trace_pc    = trace_valid ? head_rec.pc   : '0;
  assign trace_wfid  = trace_valid ? head_rec.wfid : '0;
  assign trace_seq   = trace_valid ? head_rec.seq  : '0;
  assign fifo_level  = level_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Randomized and directed stimulus for retire_trace_buf against a queue-based reference model and scoreboard.
module tb_retire_trace_buf;
  localparam int NU = 6, D = 16, UW = 3, NCH = NU + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NU-1:0]       retire_valid;
  logic [NU*32-1:0]    retire_pc;
  logic [NU*6-1:0]     retire_wfid;
  logic                issue_halt;
  logic [5:0]          issue_halt_wfid;
  logic                trace_valid, trace_ready;
  logic [UW-1:0]       trace_unit;
  logic [31:0]         trace_pc;
  logic [5:0]          trace_wfid;
  logic [15:0]         trace_seq;
  logic [$clog2(D):0]  fifo_level;
  logic [15:0]         drop_count;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]         trace_ts;
`endif

  retire_trace_buf #(.NUM_UNITS(NU), .DEPTH(D), .UNIT_W(UW)) dut (
    .clk(clk), .rst(rst),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_wfid(retire_wfid),
    .issue_halt(issue_halt), .issue_halt_wfid(issue_halt_wfid),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_unit(trace_unit), .trace_pc(trace_pc), .trace_wfid(trace_wfid),
    .trace_seq(trace_seq), .fifo_level(fifo_level), .drop_count(drop_count)
`ifdef TRACE_TIMESTAMP_EN
    ,.trace_ts(trace_ts)
`endif
  );

  typedef struct {
    int          unit;
    logic [31:0] pc;
    logic [5:0]  wfid;
    logic [15:0] seq;
    logic [31:0] ts;
  } rec_t;

  rec_t        exp_q[$];
  int          vectors = 0, miscompares = 0;
  bit          pend [NCH];
  logic [31:0] ppc  [NCH];
  logic [5:0]  pwf  [NCH];
  logic [31:0] pts  [NCH];
  int          last, mlevel, mdrop;
  logic [15:0] mseq;
  logic [31:0] mts;
  int          shown_level = 0, shown_drop = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: event-level rules applied once per clock to the current inputs.
  task automatic model_step();
    bit   pop, can, s;
    int   g, c;
    rec_t r;
    if (rst) begin
      for (int k = 0; k < NCH; k++) pend[k] = 1'b0;
      last = NCH - 1; mlevel = 0; mdrop = 0; mseq = 0; mts = 0;
      exp_q.delete();
      return;
    end
    pop = (mlevel > 0) && trace_ready;
    can = (mlevel < D) || pop;
    g = -1;
    if (can) begin
      for (int i = 1; i <= NCH; i++) begin
        c = (last + i) % NCH;
        if (g < 0 && pend[c]) g = c;
      end
    end
    if (g >= 0) begin
      r.unit = g; r.pc = ppc[g]; r.wfid = pwf[g]; r.seq = mseq; r.ts = pts[g];
      exp_q.push_back(r);
      mseq = mseq + 16'd1;
      pend[g] = 1'b0;
      last = g;
    end
    mlevel = mlevel + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    for (int k = 0; k < NCH; k++) begin
      s = (k < NU) ? retire_valid[k] : issue_halt;
      if (s) begin
        if (!pend[k]) begin
          pend[k] = 1'b1;
          ppc[k]  = (k < NU) ? retire_pc[32*k +: 32] : 32'd0;
          pwf[k]  = (k < NU) ? retire_wfid[6*k +: 6] : issue_halt_wfid;
          pts[k]  = mts;
        end else if (mdrop < 65535) begin
          mdrop++;
        end
      end
    end
    mts = mts + 32'd1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    shown_level = mlevel;
    shown_drop  = mdrop;
    mon_en      = 1'b1;
    #1;
  endtask

  task automatic clear_in();
    retire_valid = '0;
    issue_halt   = 1'b0;
  endtask

  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("fifo_level", fifo_level, shown_level);
        chk("drop_count", drop_count, shown_drop);
        chk("trace_valid", trace_valid, shown_level != 0);
        if (!rst) begin
          if (trace_valid) begin
            if (exp_q.size() == 0) begin
              chk("rec_expected", 0, 1);
            end else begin
              e = exp_q[0];
              chk("rec_unit", trace_unit, e.unit);
              chk("rec_pc", trace_pc, e.pc);
              chk("rec_wfid", trace_wfid, e.wfid);
              chk("rec_seq", trace_seq, e.seq);
`ifdef TRACE_TIMESTAMP_EN
              chk("rec_ts", trace_ts, e.ts);
`endif
              if (trace_ready) void'(exp_q.pop_front());
            end
          end else begin
            chk("idle_zero", {trace_unit, trace_pc, trace_wfid, trace_seq}, 0);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; trace_ready = 1'b1;
    retire_pc = '0; retire_wfid = '0; issue_halt_wfid = '0;
    clear_in();
    tick(); tick();
    rst = 1'b0;
    tick();

    // single retire, first record latency and contents
    retire_valid[0] = 1'b1; retire_pc[31:0] = 32'h10; retire_wfid[5:0] = 6'd3;
    tick(); clear_in();
    chk("lat_cycle1_valid", trace_valid, 1'b0);
    tick();
    chk("lat_cycle2_valid", trace_valid, 1'b1);
    chk("first_pc", trace_pc, 32'h10);
    chk("first_seq", trace_seq, 16'd0);
    tick(); tick();

    // all channels at once
    for (int c = 0; c < NU; c++) begin
      retire_pc[32*c +: 32] = 32'h100 + 32'(c); retire_wfid[6*c +: 6] = 6'(c + 8);
    end
    retire_valid = '1; issue_halt = 1'b1; issue_halt_wfid = 6'd33;
    tick(); clear_in();
    repeat (10) tick();
    chk("all_units_no_drop", drop_count, 16'd0);

    // fill with back-pressure, overflow the staging slot
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      retire_valid[1] = 1'b1; retire_pc[63:32] = 32'h2000 + 32'(i); retire_wfid[11:6] = 6'(i);
      tick();
    end
    clear_in(); tick();
    chk("full_level", fifo_level, 16);
    chk("full_drops", drop_count, 16'd3);

    // push and pop while full
    trace_ready = 1'b1; retire_valid[2] = 1'b1; retire_pc[95:64] = 32'hABCD;
    tick(); clear_in(); trace_ready = 1'b0;
    chk("full_pushpop_level", fifo_level, 16);
    trace_ready = 1'b1;
    repeat (25) tick();

    // reset with records buffered
    trace_ready = 1'b0; retire_valid = 6'b011111;
    tick(); clear_in();
    repeat (6) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_valid", trace_valid, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drops", drop_count, 16'd0);
    trace_ready = 1'b1; retire_valid[3] = 1'b1; retire_pc[127:96] = 32'h77;
    tick(); clear_in(); tick();
    chk("post_rst_seq", trace_seq, 16'd0);
    tick(); tick();

    // randomized traffic with phases of heavy back-pressure
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NU; c++) begin
        retire_valid[c]       = ($urandom_range(0, 3) == 0);
        retire_pc[32*c +: 32] = $urandom();
        retire_wfid[6*c +: 6] = 6'($urandom());
      end
      issue_halt      = ($urandom_range(0, 5) == 0);
      issue_halt_wfid = 6'($urandom());
      trace_ready     = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rst             = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0; clear_in(); trace_ready = 1'b1;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
